// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline, alignment-stage and data-cache signals of the MEM-stage load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flush;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic [31:0] raw_addr;
  logic [31:0] raw_wdata;
  logic [3:0]  raw_byte_enable;
  logic [31:0] raw_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic        dmem_resp;
  modport master (
    output req_valid, req_load, req_store, funct3, addr, store_data, flush, raw_rdata, dmem_resp,
    input  stall, load_data, load_valid, misaligned, raw_addr, raw_wdata, raw_byte_enable, dmem_read, dmem_write
  );
  modport slave (
    input  req_valid, req_load, req_store, funct3, addr, store_data, flush, raw_rdata, dmem_resp,
    output stall, load_data, load_valid, misaligned, raw_addr, raw_wdata, raw_byte_enable, dmem_read, dmem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I MEM-stage decode, alignment check, cache handshake, stall and load extension
module load_store_unit (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_data_q, ext;
  logic [3:0]  be_q, be_dec;
  logic [2:0]  f3_q;
  logic        is_load_q, killed_q, rd_q, wr_q;
  logic        mem_op, fault, start;
  assign mem_op = bus.req_valid & (bus.req_load | bus.req_store);
  assign fault  = (bus.funct3[1:0] == 2'b01 & bus.addr[0])
                | (bus.funct3[1:0] == 2'b10 & |bus.addr[1:0])
                | (bus.funct3[1:0] == 2'b11)
                | (bus.funct3 == 3'b110)
                | (~bus.req_load & bus.funct3[2]);
  assign start  = state_q == IDLE & mem_op & ~fault & ~bus.flush;
  assign be_dec = bus.funct3[1] ? 4'b1111 : bus.funct3[0] ? 4'b0011 : 4'b0001;
  assign ext    = f3_q[1] ? bus.raw_rdata
                : f3_q[0] ? {{16{~f3_q[2] & bus.raw_rdata[15]}}, bus.raw_rdata[15:0]}
                :           {{24{~f3_q[2] & bus.raw_rdata[7]}}, bus.raw_rdata[7:0]};
  always_comb begin
    state_d = state_q;
    state_d = start ? ACCESS
            : (state_q == ACCESS & bus.dmem_resp) ? DONE
            : state_q == DONE ? IDLE
            : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      is_load_q   <= 1'b0;
      killed_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q    <= bus.addr;
        wdata_q   <= bus.store_data;
        be_q      <= bus.req_load ? 4'b1111 : be_dec;
        f3_q      <= bus.funct3;
        is_load_q <= bus.req_load;
        killed_q  <= 1'b0;
        rd_q      <= bus.req_load;
        wr_q      <= ~bus.req_load;
      end else if (state_q == ACCESS) begin
        if (bus.flush) killed_q <= 1'b1;
        if (bus.dmem_resp) begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          if (is_load_q) load_data_q <= ext;
        end
      end
    end
  end
  assign bus.misaligned      = mem_op & state_q == IDLE & fault;
  assign bus.stall           = start | state_q == ACCESS;
  assign bus.load_valid      = state_q == DONE & is_load_q & ~killed_q;
  assign bus.load_data       = load_data_q;
  assign bus.raw_addr        = addr_q;
  assign bus.raw_wdata       = wdata_q;
  assign bus.raw_byte_enable = be_q;
  assign bus.dmem_read       = rd_q;
  assign bus.dmem_write      = wr_q;
endmodule
